// File: rtl/barrel_shift8.sv
// 8-bit registered barrel shifter.
// Rotate/shift by 0..7 through a 1/2/4 log network.
module barrel_shift8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic [1:0] m,
  input  logic [2:0] s,
  output logic [7:0] op
);

  localparam logic [1:0] M_ROL = 2'b00;
  localparam logic [1:0] M_ROR = 2'b01;
  localparam logic [1:0] M_SHL = 2'b10;
  localparam logic [1:0] M_SHR = 2'b11;

  logic [7:0] st1;
  logic [7:0] st2;
  logic [7:0] op_d;
  logic [7:0] op_q;

  // One network stage: move x by k places when en, else pass.
  function automatic logic [7:0] net_stage(
    input logic [7:0] x,
    input logic [1:0] md,
    input logic       en,
    input int         k
  );
    logic [15:0] dbl_l;
    logic [15:0] dbl_r;
    logic [7:0]  r;
    dbl_l = {x, x} << k;
    dbl_r = {x, x} >> k;
    r     = x;
    if (en) begin
      unique case (md)
        M_ROL:   r = dbl_l[15:8];
        M_ROR:   r = dbl_r[7:0];
        M_SHL:   r = x << k;
        M_SHR:   r = x >> k;
        default: r = x;
      endcase
    end
    return r;
  endfunction

  // Cascade the 1-, 2- and 4-place stages.
  always_comb begin
    st1  = net_stage(in,  m, s[0], 1);
    st2  = net_stage(st1, m, s[1], 2);
    op_d = net_stage(st2, m, s[2], 4);
  end

  // Result register; reset wins over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= 8'h00;
    end else begin
      op_q <= op_d;
    end
  end

  assign op = op_q;

endmodule

// File: tb/tb_barrel_shift8.sv
// Directed bench for barrel_shift8.
// Hand vectors, then exhaustive sweep against a bitwise model.
module tb_barrel_shift8;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [1:0] m;
  logic [2:0] s;
  logic [7:0] op;

  int vecs;
  int errs;

  barrel_shift8 dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .m   (m),
    .s   (s),
    .op  (op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(
    input logic [7:0] a,
    input logic [2:0] sh,
    input logic [1:0] md
  );
    logic [7:0] r;
    int n;
    r = 8'h00;
    n = int'(sh);
    for (int i = 0; i < 8; i++) begin
      case (md)
        2'b00: r[(i + n) % 8] = a[i];
        2'b01: r[(i + 8 - n) % 8] = a[i];
        2'b10: if (i + n < 8) r[i + n] = a[i];
        default: if (i >= n) r[i - n] = a[i];
      endcase
    end
    return r;
  endfunction

  task automatic apply(
    input logic       r,
    input logic [7:0] a,
    input logic [2:0] sh,
    input logic [1:0] md
  );
    rst = r;
    din = a;
    s   = sh;
    m   = md;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    vecs++;
    assert (op === exp) else begin
      errs++;
      $error("FAIL %s: op=%h expected %h", tag, op, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_sw [7];
    logic [2:0] s_sw   [7];
    int idx;
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    din  = 8'hF0;
    s    = 3'd3;
    m    = 2'b00;

    apply(1'b1, 8'hF0, 3'd3, 2'b00);
    chk("reset1", 8'h00);
    apply(1'b1, 8'hF0, 3'd3, 2'b00);
    chk("reset2", 8'h00);
    apply(1'b0, 8'hF0, 3'd3, 2'b00);
    chk("release", 8'h87);

    s_sw   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    exp_sw = '{8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h1E, 8'h3C, 8'h78};
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 8'hF0, s_sw[i], 2'b00);
      chk($sformatf("rol_s%0d", s_sw[i]), exp_sw[i]);
    end

    apply(1'b0, 8'hF0, 3'd1, 2'b01);
    chk("ror1", 8'h78);
    apply(1'b0, 8'hF0, 3'd4, 2'b01);
    chk("ror4", 8'h0F);
    apply(1'b0, 8'hF0, 3'd7, 2'b01);
    chk("ror7", 8'hE1);

    apply(1'b0, 8'hF0, 3'd1, 2'b10);
    chk("shl1", 8'hE0);
    apply(1'b0, 8'hF0, 3'd4, 2'b10);
    chk("shl4", 8'h00);
    apply(1'b0, 8'h81, 3'd7, 2'b11);
    chk("shr7", 8'h01);

    idx = 0;
    for (int mm = 0; mm < 4; mm++) begin
      for (int ss = 0; ss < 8; ss++) begin
        for (int v = 0; v < 256; v++) begin
          if (idx == 3000) begin
            apply(1'b1, 8'(v), 3'(ss), 2'(mm));
            chk("sweep_rst", 8'h00);
          end
          apply(1'b0, 8'(v), 3'(ss), 2'(mm));
          chk($sformatf("sw m%0d s%0d in%02h", mm, ss, v),
              model(8'(v), 3'(ss), 2'(mm)));
          idx++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
